// File: rtl/csi2_cphy_tx_sequencer.sv
// C-PHY trio TX burst sequencer: round-robin grant, LP->HS entry, data, post-amble, LP exit.
// Optional macro CSI2_CPHY_SEQ_STALL_ABORT_EN aborts a burst after STALL_MAX idle DATA cycles.
module csi2_cphy_tx_sequencer #(
    parameter int NUM_REQ    = 4,
    parameter int T_LPX      = 4,
    parameter int T_PREP     = 4,
    parameter int T_PREAMBLE = 8,
    parameter int T_POST     = 4,
    parameter int STALL_MAX  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [2:0]         trio_drive,
    output logic               hs_active,
    output logic               lp_active,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    output logic               tx_sync,
    output logic [2:0]         seq_state,
    output logic               burst_err
);
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int M1      = (T_LPX > T_PREP) ? T_LPX : T_PREP;
    localparam int M2      = (T_PREAMBLE > T_POST) ? T_PREAMBLE : T_POST;
    localparam int CNT_TOP = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_TOP + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREP     = 3'd1,
        S_PREAMBLE = 3'd2,
        S_SYNC     = 3'd3,
        S_DATA     = 3'd4,
        S_POST     = 3'd5,
        S_EXIT     = 3'd6
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               s_ready_q;
    logic [2:0]         trio_q;
    logic               hs_q;
    logic               lp_q;
    logic [7:0]         tx_byte_q;
    logic               tx_valid_q;
    logic               tx_sync_q;

    logic [PW-1:0]      pick_idx_d;
    logic [PW-1:0]      cand_d;
    logic               pick_found_d;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick_idx_d   = ptr_q;
        cand_d       = ptr_q;
        pick_found_d = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_d = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!pick_found_d && req[cand_d]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = cand_d;
            end
        end
    end

`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
    localparam int SW = $clog2(STALL_MAX + 1);
    logic [SW-1:0] stall_q;
    logic          err_q;
    assign burst_err = err_q;
`else
    assign burst_err = 1'b0;
`endif

    // Every output is loaded on the edge that enters the state it belongs to,
    // so outputs and seq_state always change together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= PW'(NUM_REQ - 1);
            gnt_q      <= '0;
            s_ready_q  <= 1'b0;
            trio_q     <= 3'b111;
            hs_q       <= 1'b0;
            lp_q       <= 1'b1;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_sync_q  <= 1'b0;
`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
            stall_q    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            tx_valid_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            tx_sync_q  <= 1'b0;
`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (pick_found_d) begin
                        gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_d;
                        ptr_q   <= pick_idx_d;
                        state_q <= S_PREP;
                        cnt_q   <= CW'(T_PREP - 1);
                        trio_q  <= 3'b000;
                        lp_q    <= 1'b0;
                    end
                end
                S_PREP: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_PREAMBLE;
                        cnt_q      <= CW'(T_PREAMBLE - 1);
                        hs_q       <= 1'b1;
                        tx_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_PREAMBLE: begin
                    if (cnt_q == '0) begin
                        state_q   <= S_SYNC;
                        tx_sync_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_q - CW'(1);
                        tx_valid_q <= 1'b1;
                    end
                end
                S_SYNC: begin
                    state_q   <= S_DATA;
                    s_ready_q <= 1'b1;
`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
                    stall_q   <= '0;
`endif
                end
                S_DATA: begin
                    if (s_valid) begin
                        tx_byte_q  <= s_data;
                        tx_valid_q <= 1'b1;
`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
                        stall_q    <= '0;
`endif
                        // The final byte drains in the first POST cycle, so POST
                        // is loaded one longer to still emit T_POST zero bytes.
                        if (s_last) begin
                            state_q   <= S_POST;
                            cnt_q     <= CW'(T_POST);
                            s_ready_q <= 1'b0;
                        end
                    end
`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
                    else if (stall_q == SW'(STALL_MAX - 1)) begin
                        state_q    <= S_POST;
                        cnt_q      <= CW'(T_POST - 1);
                        s_ready_q  <= 1'b0;
                        err_q      <= 1'b1;
                        tx_valid_q <= 1'b1;
                        stall_q    <= '0;
                    end else begin
                        stall_q <= stall_q + SW'(1);
                    end
`endif
                end
                S_POST: begin
                    if (cnt_q == '0) begin
                        state_q <= S_EXIT;
                        cnt_q   <= CW'(T_LPX - 1);
                        gnt_q   <= '0;
                        hs_q    <= 1'b0;
                        lp_q    <= 1'b1;
                        trio_q  <= 3'b111;
                    end else begin
                        cnt_q      <= cnt_q - CW'(1);
                        tx_valid_q <= 1'b1;
                    end
                end
                S_EXIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign s_ready    = s_ready_q;
    assign trio_drive = trio_q;
    assign hs_active  = hs_q;
    assign lp_active  = lp_q;
    assign tx_byte    = tx_byte_q;
    assign tx_valid   = tx_valid_q;
    assign tx_sync    = tx_sync_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_csi2_cphy_tx_sequencer.sv
// Bench for csi2_cphy_tx_sequencer: a burst-level timeline model builds the expected
// per-cycle outputs and the matching input drive; both are replayed cycle by cycle.
module tb_csi2_cphy_tx_sequencer;
    localparam int NUM_REQ    = 4;
    localparam int T_LPX      = 4;
    localparam int T_PREP     = 4;
    localparam int T_PREAMBLE = 8;
    localparam int T_POST     = 4;
    localparam int STALL_MAX  = 16;
    localparam int W          = 24;
`ifdef CSI2_CPHY_SEQ_STALL_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [7:0] s_data;
    logic s_valid;
    logic s_last;
    logic s_ready;
    logic [2:0] trio_drive;
    logic hs_active;
    logic lp_active;
    logic [7:0] tx_byte;
    logic tx_valid;
    logic tx_sync;
    logic [2:0] seq_state;
    logic burst_err;

    csi2_cphy_tx_sequencer #(
        .NUM_REQ(NUM_REQ), .T_LPX(T_LPX), .T_PREP(T_PREP),
        .T_PREAMBLE(T_PREAMBLE), .T_POST(T_POST), .STALL_MAX(STALL_MAX)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .trio_drive(trio_drive), .hs_active(hs_active), .lp_active(lp_active),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_sync(tx_sync),
        .seq_state(seq_state), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  exp_q[$];
    logic [13:0]   drv_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            ptr_m = NUM_REQ - 1;
    string         tag = "reset";
    logic [7:0]    byte_a[16];
    int            stall_a[16];

    function automatic logic [W-1:0] pk(input logic [2:0] st, input logic [2:0] tr,
                                        input logic hs, input logic lp, input logic [3:0] g,
                                        input logic rdy, input logic tv, input logic [7:0] tb,
                                        input logic sy, input logic er);
        return {st, tr, hs, lp, g, rdy, tv, tb, sy, er};
    endfunction

    function automatic logic [W-1:0] observed();
        return {seq_state, trio_drive, hs_active, lp_active, gnt, s_ready,
                tx_valid, tx_byte, tx_sync, burst_err};
    endfunction

    task automatic check(input logic [W-1:0] e);
        n_chk++;
        assert (observed() === e) n_pass++;
        else $error("FAIL %s cyc %0d: got %h expected %h", tag, cyc, observed(), e);
    endtask

    task automatic push(input logic [W-1:0] e, input logic [3:0] r, input logic v,
                        input logic l, input logic [7:0] d);
        exp_q.push_back(e);
        drv_q.push_back({r, v, l, d});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++)
            push(pk(3'd0, 3'b111, 0, 1, 4'h0, 0, 0, 8'h00, 0, 0), 4'h0, 0, 0, 8'($urandom_range(0, 255)));
    endtask

    // One burst as seen on the trio: arbitration cycle, PREP, PREAMBLE, SYNC,
    // DATA (with stalls), POST, EXIT. Bytes/stalls come from byte_a/stall_a.
    task automatic add_burst(input logic [3:0] req_first, input logic [3:0] req_rest, input int nb);
        logic [3:0] g;
        logic [7:0] prev_b;
        bit prev_hs;
        bit aborted;
        int run;
        int idx;
        g = 4'h0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (ptr_m + i) % NUM_REQ;
            if (g == 4'h0 && req_first[idx]) begin
                g[idx] = 1'b1;
                ptr_m = idx;
            end
        end
        push(pk(3'd0, 3'b111, 0, 1, 4'h0, 0, 0, 8'h00, 0, 0), req_first, 0, 0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < T_PREP; i++)
            push(pk(3'd1, 3'b000, 0, 0, g, 0, 0, 8'h00, 0, 0), req_rest, 0, 0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < T_PREAMBLE; i++)
            push(pk(3'd2, 3'b000, 1, 0, g, 0, 1, 8'h00, 0, 0), req_rest, 0, 0, 8'($urandom_range(0, 255)));
        push(pk(3'd3, 3'b000, 1, 0, g, 0, 0, 8'h00, 1, 0), req_rest, 0, 0, 8'($urandom_range(0, 255)));
        prev_hs = 1'b0;
        prev_b = 8'h00;
        aborted = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
            run = 0;
            for (int s = 0; s < stall_a[b] && !aborted; s++) begin
                run++;
                push(pk(3'd4, 3'b000, 1, 0, g, 1, prev_hs, prev_hs ? prev_b : 8'h00, 0, 0),
                     req_rest, 0, 0, 8'($urandom_range(0, 255)));
                prev_hs = 1'b0;
                if (ABORT_EN && run == STALL_MAX) aborted = 1'b1;
            end
            if (!aborted) begin
                push(pk(3'd4, 3'b000, 1, 0, g, 1, prev_hs, prev_hs ? prev_b : 8'h00, 0, 0),
                     req_rest, 1, (b == nb - 1), byte_a[b]);
                prev_hs = 1'b1;
                prev_b = byte_a[b];
            end
        end
        if (aborted) begin
            for (int i = 0; i < T_POST; i++)
                push(pk(3'd5, 3'b000, 1, 0, g, 0, 1, 8'h00, 0, (i == 0)), req_rest, 0, 0, 8'h00);
        end else begin
            push(pk(3'd5, 3'b000, 1, 0, g, 0, 1, prev_b, 0, 0), req_rest, 0, 0, 8'h00);
            for (int i = 0; i < T_POST; i++)
                push(pk(3'd5, 3'b000, 1, 0, g, 0, 1, 8'h00, 0, 0), req_rest, 0, 0, 8'h00);
        end
        for (int i = 0; i < T_LPX; i++)
            push(pk(3'd6, 3'b111, 0, 1, 4'h0, 0, 0, 8'h00, 0, 0), req_rest, 0, 0, 8'h00);
    endtask

    // Called at posedge+1: drive this cycle's inputs, check this cycle's outputs.
    task automatic run_queue(input int limit);
        logic [13:0] d;
        int n;
        n = 0;
        while (drv_q.size() > 0 && n < limit) begin
            d = drv_q.pop_front();
            req = d[13:10];
            s_valid = d[9];
            s_last = d[8];
            s_data = d[7:0];
            check(exp_q.pop_front());
            @(posedge clk);
            #1;
            cyc++;
            n++;
        end
        exp_q.delete();
        drv_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 4'h0;
        s_valid = 1'b0;
        s_last = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check(pk(3'd0, 3'b111, 0, 1, 4'h0, 0, 0, 8'h00, 0, 0));
        reset = 1'b0;
        ptr_m = NUM_REQ - 1;
    endtask

    task automatic rand_bytes(input int nb, input int max_stall);
        for (int i = 0; i < nb; i++) begin
            byte_a[i] = 8'($urandom_range(0, 255));
            stall_a[i] = $urandom_range(0, max_stall);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 4'h0;
        s_data = 8'h00;
        s_valid = 1'b0;
        s_last = 1'b0;
        @(posedge clk);
        do_reset();

        tag = "single_burst";
        byte_a[0] = 8'hA1; byte_a[1] = 8'hB2; byte_a[2] = 8'hC3;
        stall_a[0] = 0; stall_a[1] = 0; stall_a[2] = 0;
        add_burst(4'b0001, 4'b0001, 3);
        add_idle(2);
        run_queue(10000);

        tag = "rr_all";
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rand_bytes($urandom_range(1, 4), 1);
            add_burst(4'b1111, 4'b1111, 4);
        end
        add_idle(1);
        run_queue(10000);

        tag = "stall3";
        byte_a[0] = 8'h11; byte_a[1] = 8'h22; byte_a[2] = 8'h33; byte_a[3] = 8'h44;
        stall_a[0] = 0; stall_a[1] = 0; stall_a[2] = 3; stall_a[3] = 0;
        add_burst(4'b0010, 4'b0010, 4);
        add_idle(1);
        run_queue(10000);

        tag = "late_req2";
        rand_bytes(3, 2);
        add_burst(4'b0001, 4'b0101, 3);
        rand_bytes(2, 0);
        add_burst(4'b0100, 4'b0000, 2);
        add_idle(1);
        run_queue(10000);

        tag = "long_stall";
        byte_a[0] = 8'h5A; byte_a[1] = 8'hA5; byte_a[2] = 8'h3C;
        stall_a[0] = 0; stall_a[1] = 20; stall_a[2] = 0;
        add_burst(4'b1000, 4'b0000, 3);
        add_idle(2);
        run_queue(10000);

        tag = "random";
        for (int k = 0; k < 6; k++) begin
            int nb;
            nb = $urandom_range(1, 6);
            rand_bytes(nb, 4);
            add_burst(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), nb);
            add_idle($urandom_range(0, 3));
        end
        run_queue(10000);

        tag = "reset_in_data";
        rand_bytes(5, 0);
        add_burst(4'b0100, 4'b0100, 5);
        run_queue(1 + T_PREP + T_PREAMBLE + 1 + 2);
        do_reset();

        tag = "after_reset";
        rand_bytes(2, 1);
        add_burst(4'b1111, 4'b0000, 2);
        add_idle(1);
        run_queue(10000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
